// File: rtl/ishift_gen.sv
// Iterative shifter/rotator: moves CHUNK bits per cycle while at least CHUNK
// remain, then one bit per cycle. Supports LSR/LSL/ASR, full-width and 32-bit rotates.
module ishift_gen #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 6,
    parameter int CW    = 7
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             go,
    input  logic             abort,
    input  logic [2:0]       fmt,
    input  logic [CW-1:0]    cnt,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic [WIDTH-1:0] y
);

    typedef enum logic [2:0] {
        OP_LSR   = 3'd0,
        OP_LSL   = 3'd1,
        OP_ASR   = 3'd2,
        OP_ROL   = 3'd3,
        OP_ROR   = 3'd4,
        OP_ROR32 = 3'd5
    } op_e;

    localparam logic [CW-1:0]    WIDTH_C  = CW'(WIDTH);
    localparam logic [CW-1:0]    CHUNK_C  = CW'(CHUNK);
    localparam logic [CW-1:0]    ONE_C    = CW'(1);
    localparam logic [CW-1:0]    ROT_MASK = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    R32_MASK = CW'(31);
    localparam logic [WIDTH-1:0] LSB1     = WIDTH'(1);

    op_e              op_q, op_d, op_in;
    logic [WIDTH-1:0] y_q, y_d, a_ld;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [CW-1:0]    n_eff, step;
    logic             big;
    logic [WIDTH:0]   step_res;

    // One step of amt bits; returns {bit shifted out last, new word}.
    function automatic logic [WIDTH:0] step_op(input logic [WIDTH-1:0] v, input op_e op,
                                               input int amt);
        logic [WIDTH-1:0] r;
        logic [31:0]      lo;
        logic             c;
        lo = v[31:0];
        r  = v >> amt;
        c  = |(v & (LSB1 << (amt - 1)));
        case (op)
            OP_LSL: begin
                r = v << amt;
                c = |(v & (LSB1 << (WIDTH - amt)));
            end
            OP_ROL: begin
                r = (v << amt) | (v >> (WIDTH - amt));
                c = |(v & (LSB1 << (WIDTH - amt)));
            end
            OP_ASR:   r = WIDTH'($signed(v) >>> amt);
            OP_ROR:   r = (v >> amt) | (v << (WIDTH - amt));
            OP_ROR32: begin
                r       = '0;
                r[31:0] = (lo >> amt) | (lo << (32 - amt));
            end
            default:  r = v >> amt;
        endcase
        return {c, r};
    endfunction

    // Handshake: go is taken on a rising edge only while busy is low; the caller
    // holds off while busy is high and collects y/carry when done pulses.
    always_comb begin
        op_in = (fmt > 3'd5) ? OP_LSR : op_e'(fmt);
        case (op_in)
            OP_ROL, OP_ROR: n_eff = cnt & ROT_MASK;
            OP_ROR32:       n_eff = cnt & R32_MASK;
            default:        n_eff = (cnt > WIDTH_C) ? WIDTH_C : cnt;
        endcase
        a_ld = a;
        if (op_in == OP_ROR32) begin
            a_ld       = '0;
            a_ld[31:0] = a[31:0];
        end
        big      = (rem_q >= CHUNK_C);
        step     = big ? CHUNK_C : ONE_C;
        step_res = big ? step_op(y_q, op_q, CHUNK) : step_op(y_q, op_q, 1);

        op_d    = op_q;
        y_d     = y_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        rem_d   = rem_q;
        done_d  = 1'b0;

        if (busy_q) begin
            // Abort wins over a completion landing on the same edge.
            if (abort) begin
                busy_d = 1'b0;
                rem_d  = '0;
            end else begin
                y_d     = step_res[WIDTH-1:0];
                carry_d = step_res[WIDTH];
                rem_d   = rem_q - step;
                if (rem_q == step) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
        end else if (go) begin
            op_d    = op_in;
            y_d     = a_ld;
            carry_d = 1'b0;
            rem_d   = n_eff;
            busy_d  = (n_eff != '0);
            done_d  = (n_eff == '0);
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            op_q    <= OP_LSR;
            y_q     <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            op_q    <= op_d;
            y_q     <= y_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
        end
    end

    assign y     = y_q;
    assign carry = carry_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_ishift_gen.sv
// Bench for ishift_gen: a 32-bit and a 64-bit instance share the operand bus;
// expected events are queued by the driver and retired by a single monitor.
module tb_ishift_gen;

    localparam logic [1:0] K_DONE = 2'd0;
    localparam logic [1:0] K_ABT  = 2'd1;
    localparam logic [1:0] K_RST  = 2'd2;
    localparam logic [1:0] K_NONE = 2'd3;

    typedef struct packed {
        logic [0:0]  dut;
        logic [1:0]  kind;
        logic [63:0] y;
        logic        c;
        logic [15:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        arstn;
    logic        abort;
    logic [2:0]  fmt;
    logic [6:0]  cnt;
    logic [63:0] a;
    logic        go32, go64;
    logic        busy32, done32, carry32;
    logic [31:0] y32;
    logic        busy64, done64, carry64;
    logic [63:0] y64;

    exp_t        exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic        end_req = 1'b0;
    logic        end_ack = 1'b0;

    always #5 clk = ~clk;

    ishift_gen #(.WIDTH(32), .CHUNK(6), .CW(7)) dut32 (
        .clk(clk), .arstn(arstn), .go(go32), .abort(abort), .fmt(fmt), .cnt(cnt),
        .a(a[31:0]), .busy(busy32), .done(done32), .carry(carry32), .y(y32)
    );

    ishift_gen #(.WIDTH(64), .CHUNK(6), .CW(7)) dut64 (
        .clk(clk), .arstn(arstn), .go(go64), .abort(abort), .fmt(fmt), .cnt(cnt),
        .a(a), .busy(busy64), .done(done64), .carry(carry64), .y(y64)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: the only process that compares.
    int          mon_cyc[2];
    logic        mon_pbusy[2];
    logic        mon_pdone[2];
    logic        mon_b, mon_dn, mon_cr;
    logic [63:0] mon_y;
    logic [1:0]  mon_kind, mon_ek;
    exp_t        mon_e;

    initial begin
        for (int d = 0; d < 2; d++) begin
            mon_cyc[d]   = 0;
            mon_pbusy[d] = 1'b0;
            mon_pdone[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                mon_b  = (d == 0) ? busy32  : busy64;
                mon_dn = (d == 0) ? done32  : done64;
                mon_cr = (d == 0) ? carry32 : carry64;
                mon_y  = (d == 0) ? {32'b0, y32} : y64;
                if (!arstn) begin
                    if (exp_q.size() > 0 && exp_q[0].kind == K_RST && int'(exp_q[0].dut) == d) begin
                        mon_e = exp_q.pop_front();
                        check($sformatf("rst_y[%0d]", d), mon_y, 64'd0);
                        check($sformatf("rst_busy[%0d]", d), 64'(mon_b), 64'd0);
                        check($sformatf("rst_done[%0d]", d), 64'(mon_dn), 64'd0);
                        check($sformatf("rst_carry[%0d]", d), 64'(mon_cr), 64'd0);
                    end
                    mon_cyc[d]   = 0;
                    mon_pbusy[d] = 1'b0;
                    mon_pdone[d] = 1'b0;
                end else begin
                    if (mon_b) mon_cyc[d]++;
                    if (mon_dn || (mon_pbusy[d] && !mon_b)) begin
                        mon_kind = mon_dn ? K_DONE : K_ABT;
                        if (mon_dn) check($sformatf("done_prev_low[%0d]", d), 64'(mon_pdone[d]), 64'd0);
                        mon_ek = K_NONE;
                        if (exp_q.size() > 0 && int'(exp_q[0].dut) == d) mon_ek = exp_q[0].kind;
                        check($sformatf("event_kind[%0d]", d), 64'(mon_kind), 64'(mon_ek));
                        if (mon_kind == mon_ek) begin
                            mon_e = exp_q.pop_front();
                            check($sformatf("y[%0d]", d), mon_y, mon_e.y);
                            check($sformatf("carry[%0d]", d), 64'(mon_cr), 64'(mon_e.c));
                            check($sformatf("busy_cycles[%0d]", d), 64'(mon_cyc[d]), 64'(mon_e.cyc));
                        end
                        mon_cyc[d] = 0;
                    end
                    mon_pbusy[d] = mon_b;
                    mon_pdone[d] = mon_dn;
                end
            end
            if (end_req && !end_ack) begin
                check("queue_empty", 64'(exp_q.size()), 64'd0);
                end_ack = 1'b1;
            end
        end
    end

    task automatic push_exp(input int d, input logic [1:0] kind, input logic [63:0] ey,
                            input logic ec, input int ecyc);
        exp_t e;
        e.dut  = 1'(d);
        e.kind = kind;
        e.y    = ey;
        e.c    = ec;
        e.cyc  = 16'(ecyc);
        exp_q.push_back(e);
    endtask

    task automatic set_go(input int d, input logic v);
        if (d == 0) go32 = v;
        else        go64 = v;
    endtask

    // abort_at / go_at: negedge index after acceptance at which to pulse abort / a stray go.
    task automatic run_op(input int d, input logic [2:0] f, input logic [6:0] c,
                          input logic [63:0] av, input logic [1:0] kind, input logic [63:0] ey,
                          input logic ec, input int ecyc, input int abort_at, input int go_at,
                          input logic abort_on_go);
        @(negedge clk);
        push_exp(d, kind, ey, ec, ecyc);
        fmt   = f;
        cnt   = c;
        a     = av;
        abort = abort_on_go;
        set_go(d, 1'b1);
        @(negedge clk);
        set_go(d, 1'b0);
        abort = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            if (!((d == 0) ? busy32 : busy64)) break;
            abort = (i == abort_at);
            set_go(d, i == go_at);
            if (i == go_at) begin
                a   = ~av;
                fmt = 3'd4;
                cnt = 7'd0;
            end
            @(negedge clk);
        end
        abort = 1'b0;
        set_go(d, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        arstn = 1'b0;
        abort = 1'b0;
        go32  = 1'b0;
        go64  = 1'b0;
        fmt   = 3'd0;
        cnt   = 7'd0;
        a     = 64'd0;
        push_exp(0, K_RST, 64'd0, 1'b0, 0);
        push_exp(1, K_RST, 64'd0, 1'b0, 0);
        repeat (3) @(negedge clk);
        arstn = 1'b1;

        // 32-bit instance
        run_op(0, 3'd0, 7'd13, 64'h80000001, K_DONE, 64'h00040000, 1'b0, 3, 0, 0, 1'b0);
        run_op(0, 3'd2, 7'd40, 64'h80000000, K_DONE, 64'hFFFFFFFF, 1'b1, 7, 0, 0, 1'b0);
        run_op(0, 3'd3, 7'd36, 64'h12345678, K_DONE, 64'h23456781, 1'b1, 4, 0, 0, 1'b0);
        run_op(0, 3'd4, 7'd1,  64'h00000001, K_DONE, 64'h80000000, 1'b1, 1, 0, 0, 1'b0);
        run_op(0, 3'd4, 7'd6,  64'h00000020, K_DONE, 64'h80000000, 1'b1, 1, 0, 0, 1'b0);
        run_op(0, 3'd1, 7'd6,  64'h04000000, K_DONE, 64'h00000000, 1'b1, 1, 0, 0, 1'b0);
        run_op(0, 3'd1, 7'd0,  64'hDEADBEEF, K_DONE, 64'hDEADBEEF, 1'b0, 0, 0, 0, 1'b0);
        run_op(0, 3'd6, 7'd6,  64'h80000000, K_DONE, 64'h02000000, 1'b0, 1, 0, 0, 1'b0);
        run_op(0, 3'd5, 7'd33, 64'h00000003, K_DONE, 64'h80000001, 1'b1, 1, 0, 0, 1'b0);
        run_op(0, 3'd1, 7'd8,  64'h00000001, K_DONE, 64'h00000100, 1'b0, 3, 0, 2, 1'b0);
        run_op(0, 3'd1, 7'd20, 64'h00000001, K_ABT,  64'h00001000, 1'b0, 3, 3, 0, 1'b0);
        run_op(0, 3'd0, 7'd4,  64'h000000F8, K_DONE, 64'h0000000F, 1'b1, 4, 0, 0, 1'b1);

        // 64-bit instance
        run_op(1, 3'd5, 7'd1,   64'hFFFFFFFF00000001, K_DONE, 64'h0000000080000000, 1'b1, 1, 0, 0, 1'b0);
        run_op(1, 3'd1, 7'd63,  64'h0000000000000001, K_DONE, 64'h8000000000000000, 1'b0, 13, 0, 0, 1'b0);
        run_op(1, 3'd4, 7'd65,  64'h0000000000000001, K_DONE, 64'h8000000000000000, 1'b1, 1, 0, 0, 1'b0);
        run_op(1, 3'd2, 7'd100, 64'h8000000000000000, K_DONE, 64'hFFFFFFFFFFFFFFFF, 1'b1, 14, 0, 0, 1'b0);
        run_op(1, 3'd0, 7'd127, 64'hF000000000000000, K_DONE, 64'h0000000000000000, 1'b1, 14, 0, 0, 1'b0);

        // Reset dropped between clock edges in the middle of a 32-bit LSR.
        @(negedge clk);
        fmt  = 3'd0;
        cnt  = 7'd31;
        a    = 64'hFFFFFFFF;
        go32 = 1'b1;
        @(negedge clk);
        go32 = 1'b0;
        @(negedge clk);
        push_exp(0, K_RST, 64'd0, 1'b0, 0);
        push_exp(1, K_RST, 64'd0, 1'b0, 0);
        @(posedge clk);
        #1 arstn = 1'b0;
        repeat (2) @(negedge clk);
        arstn = 1'b1;

        run_op(0, 3'd4, 7'd1, 64'h00000001, K_DONE, 64'h80000000, 1'b1, 1, 0, 0, 1'b0);

        end_req = 1'b1;
        for (int i = 0; i < 10 && !end_ack; i++) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
